aes128_cbc_stream_dec: RTL

//  Streaming AES-128 CBC decrypt controller. Accepts back-to-back ciphertext blocks on a

---
 rtl/aes128_cbc_stream_dec.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes128_cbc_stream_dec.sv
// Streaming AES-128 CBC decrypt controller.
// Feeds ciphertext blocks to an external fixed-latency ECB decrypt core, keeps the
// chaining value for each in-flight block in a side FIFO, XORs the core result with
// it and queues the plaintext behind a valid/ready output port.
// Optional build macro AES_CBC_IV_READBACK_EN adds a chain_out port that exposes the
// live chain register for context save/restore.
module aes128_cbc_stream_dec #(
  parameter int CORE_LAT  = 10,
  parameter int KEY_LAT   = 11,
  parameter int OUT_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  input  logic [127:0] iv_in,
  input  logic         iv_load,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic [127:0] core_key,
  output logic         core_in_valid,
  output logic [127:0] core_in_data,
  input  logic         core_out_valid,
  input  logic [127:0] core_out_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         err
`ifdef AES_CBC_IV_READBACK_EN
  ,
  output logic [127:0] chain_out
`endif
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int KW = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LAT - 1);
  localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(OUT_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Every block issued to the core must have a side-FIFO slot until its result returns.
  if (OUT_DEPTH < CORE_LAT + 1) begin : g_depth_check
    $error("OUT_DEPTH must be at least CORE_LAT+1");
  end

  logic [1:0]    state;
  logic [KW-1:0] key_cnt;
  logic [127:0]  key_reg;
  logic [127:0]  iv_reg;
  logic [127:0]  chain_reg;
  logic          msg_open;
  logic          err_reg;
  logic          core_in_valid_reg;
  logic [127:0]  core_in_data_reg;

  logic [127:0]  side_chain [OUT_DEPTH];
  logic          side_last  [OUT_DEPTH];
  logic [AW-1:0] side_wr, side_rd;
  logic [CW-1:0] side_cnt;

  logic [127:0]  out_data [OUT_DEPTH];
  logic          out_last [OUT_DEPTH];
  logic [AW-1:0] out_wr, out_rd;
  logic [CW-1:0] out_cnt;

  logic [CW:0]   occ;
  logic          acc, side_pop, out_pop, key_go;

  // Handshake and credit decode: in-flight plus buffered blocks never exceed the FIFO depth.
  always_comb begin
    occ       = {1'b0, side_cnt} + {1'b0, out_cnt};
    busy      = (side_cnt != '0) || (out_cnt != '0);
    key_ready = (state == ST_READY);
    s_ready   = key_ready && (occ < DEPTH_V);
    acc       = s_valid && s_ready;
    side_pop  = core_out_valid && (side_cnt != '0);
    m_valid   = (out_cnt != '0);
    out_pop   = m_valid && m_ready;
    key_go    = key_load && !busy;
    m_data    = m_valid ? out_data[out_rd] : '0;
    m_last    = m_valid ? out_last[out_rd] : 1'b0;
  end

  assign core_key      = key_reg;
  assign core_in_valid = core_in_valid_reg;
  assign core_in_data  = core_in_data_reg;
  assign err           = err_reg;
`ifdef AES_CBC_IV_READBACK_EN
  assign chain_out     = chain_reg;
`endif

  // Key FSM: latch the key, wait out the core's key expansion, then open the input port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      key_cnt <= '0;
      key_reg <= '0;
    end else if (key_go) begin
      state   <= ST_EXPAND;
      key_cnt <= '0;
      key_reg <= key_in;
    end else if (state == ST_EXPAND) begin
      if (key_cnt == KEY_LAST) state <= ST_READY;
      else                     key_cnt <= key_cnt + KW'(1);
    end
  end

  // Issue register, IV/chain tracking and the sticky protocol error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_in_valid_reg <= 1'b0;
      core_in_data_reg  <= '0;
      iv_reg            <= '0;
      chain_reg         <= '0;
      msg_open          <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      core_in_valid_reg <= acc;
      if (acc) core_in_data_reg <= s_data;
      if (iv_load) iv_reg <= iv_in;
      if (acc) begin
        // A finished message re-seeds the chain with the newest IV for the next one.
        chain_reg <= s_last ? (iv_load ? iv_in : iv_reg) : s_data;
        msg_open  <= !s_last;
      end else if (iv_load && !msg_open) begin
        chain_reg <= iv_in;
      end
      if ((key_load && busy) || (core_out_valid && side_cnt == '0)) err_reg <= 1'b1;
    end
  end

  // Side and output FIFO pointers/counts; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      side_wr  <= '0;
      side_rd  <= '0;
      side_cnt <= '0;
      out_wr   <= '0;
      out_rd   <= '0;
      out_cnt  <= '0;
    end else begin
      if (acc)      side_wr <= side_wr + AW'(1);
      if (side_pop) side_rd <= side_rd + AW'(1);
      case ({acc, side_pop})
        2'b10:   side_cnt <= side_cnt + CW'(1);
        2'b01:   side_cnt <= side_cnt - CW'(1);
        default: side_cnt <= side_cnt;
      endcase
      if (side_pop) out_wr <= out_wr + AW'(1);
      if (out_pop)  out_rd <= out_rd + AW'(1);
      case ({side_pop, out_pop})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // FIFO storage: chain value per issued block, then the finished plaintext.
  always_ff @(posedge clk) begin
    if (acc) begin
      side_chain[side_wr] <= chain_reg;
      side_last[side_wr]  <= s_last;
    end
    if (side_pop) begin
      out_data[out_wr] <= core_out_data ^ side_chain[side_rd];
      out_last[out_wr] <= side_last[side_rd];
    end
  end

endmodule
